// File: rtl/pipe_ctrl_if.sv
// Signal bundle between pipe_ctrl and the CPU stage registers.
// master = CPU datapath side, slave = pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int ADDR_W = 30,
    parameter int EXP_W  = 3
);
    logic              if_busy;
    logic              mem_busy;
    logic              ld_hazard;
    logic              br_taken;
    logic [ADDR_W-1:0] br_addr;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_pc;
    logic [EXP_W-1:0]  mem_exp_code;
    logic              mem_eret;
    logic              mem_halt;
    logic              int_req;
    logic              int_en_we;
    logic              int_en_wd;
    logic              if_stall;
    logic              id_stall;
    logic              ex_stall;
    logic              mem_stall;
    logic              if_flush;
    logic              id_flush;
    logic              ex_flush;
    logic              mem_flush;
    logic              pc_load;
    logic [ADDR_W-1:0] new_pc;
    logic [ADDR_W-1:0] epc;
    logic [EXP_W-1:0]  exp_code_q;
    logic              int_en;

    modport master (
        output if_busy, mem_busy, ld_hazard, br_taken, br_addr,
        output mem_en, mem_pc, mem_exp_code, mem_eret, mem_halt,
        output int_req, int_en_we, int_en_wd,
        input  if_stall, id_stall, ex_stall, mem_stall,
        input  if_flush, id_flush, ex_flush, mem_flush,
        input  pc_load, new_pc, epc, exp_code_q, int_en
    );

    modport slave (
        input  if_busy, mem_busy, ld_hazard, br_taken, br_addr,
        input  mem_en, mem_pc, mem_exp_code, mem_eret, mem_halt,
        input  int_req, int_en_we, int_en_wd,
        output if_stall, id_stall, ex_stall, mem_stall,
        output if_flush, id_flush, ex_flush, mem_flush,
        output pc_load, new_pc, epc, exp_code_q, int_en
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control for the IF/ID/EX/MEM core: stall/flush per stage,
// PC redirect on branch/trap/ERET, and EPC / exception code / int enable.
module pipe_ctrl #(
    parameter int                ADDR_W     = 30,
    parameter int                EXP_W      = 3,
    parameter logic [ADDR_W-1:0] EXP_VECTOR = 30'h100,
    parameter logic [EXP_W-1:0]  EXP_INT    = 3'd1
) (
    input logic         clk,
    input logic         reset_,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        HALT     = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [EXP_W-1:0]  code_q, code_d;
    logic              ie_q, ie_d;
    logic              sie_q, sie_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;

    // Vectors ordered {if, id, ex, mem}
    logic [3:0]        stall;
    logic [3:0]        flush;
    logic              pcl;
    logic [ADDR_W-1:0] npc;
    logic              busy;
    logic              trap;
    logic              irq;

    assign busy = bus.if_busy | bus.mem_busy;
    assign irq  = bus.int_req & ie_q;
    assign trap = bus.mem_en & ((bus.mem_exp_code != '0) | irq);

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q <= RUN;
            epc_q   <= '0;
            code_q  <= '0;
            ie_q    <= 1'b0;
            sie_q   <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            code_q  <= code_d;
            ie_q    <= ie_d;
            sie_q   <= sie_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        code_d  = code_q;
        ie_d    = ie_q;
        sie_d   = sie_q;
        tgt_d   = tgt_q;
        stall   = 4'b0000;
        flush   = 4'b0000;
        pcl     = 1'b0;
        npc     = '0;
        unique case (state_q)
            RUN: begin
                if (bus.int_en_we) ie_d = bus.int_en_wd;
                if (!busy) begin
                    if (trap) begin
                        flush   = 4'b1111;
                        epc_d   = bus.mem_pc;
                        code_d  = (bus.mem_exp_code != '0) ?
                                  bus.mem_exp_code : EXP_INT;
                        sie_d   = ie_q;
                        ie_d    = 1'b0;
                        tgt_d   = EXP_VECTOR;
                        state_d = REDIRECT;
                    end else if (bus.mem_en & bus.mem_eret) begin
                        flush   = 4'b1111;
                        ie_d    = sie_q;
                        tgt_d   = epc_q;
                        state_d = REDIRECT;
                    end else if (bus.mem_en & bus.mem_halt) begin
                        flush   = 4'b1110;
                        state_d = HALT;
                    end else if (bus.br_taken) begin
                        pcl   = 1'b1;
                        npc   = bus.br_addr;
                        flush = 4'b1000;
                    end else if (bus.ld_hazard) begin
                        stall = 4'b1000;
                        flush = 4'b0100;
                    end
                end
            end
            REDIRECT: begin
                // Flush stays up while IF is stalled so it is not lost
                pcl   = 1'b1;
                npc   = tgt_q;
                flush = 4'b1000;
                if (!bus.if_busy) state_d = RUN;
            end
            HALT: begin
                stall = 4'b1111;
                if (irq) begin
                    epc_d   = bus.mem_pc + ADDR_W'(1);
                    code_d  = EXP_INT;
                    sie_d   = ie_q;
                    ie_d    = 1'b0;
                    tgt_d   = EXP_VECTOR;
                    state_d = REDIRECT;
                end
            end
            default: state_d = RUN;
        endcase
        if (busy) stall = 4'b1111;
    end

    assign bus.if_stall   = stall[3];
    assign bus.id_stall   = stall[2];
    assign bus.ex_stall   = stall[1];
    assign bus.mem_stall  = stall[0];
    assign bus.if_flush   = flush[3];
    assign bus.id_flush   = flush[2];
    assign bus.ex_flush   = flush[1];
    assign bus.mem_flush  = flush[0];
    assign bus.pc_load    = pcl;
    assign bus.new_pc     = npc;
    assign bus.epc        = epc_q;
    assign bus.exp_code_q = code_q;
    assign bus.int_en     = ie_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected output snapshots are queued
// as each step is driven and popped for comparison before the clock edge.
module tb_pipe_ctrl;

    logic clk;
    logic reset_;

    pipe_ctrl_if #(.ADDR_W(30), .EXP_W(3)) bus ();

    pipe_ctrl dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [72:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic idle();
        bus.if_busy      = 1'b0;
        bus.mem_busy     = 1'b0;
        bus.ld_hazard    = 1'b0;
        bus.br_taken     = 1'b0;
        bus.br_addr      = '0;
        bus.mem_en       = 1'b0;
        bus.mem_pc       = '0;
        bus.mem_exp_code = '0;
        bus.mem_eret     = 1'b0;
        bus.mem_halt     = 1'b0;
        bus.int_req      = 1'b0;
        bus.int_en_we    = 1'b0;
        bus.int_en_wd    = 1'b0;
    endtask

    // st/fl ordered {if, id, ex, mem}
    task automatic push_exp(input string tag, input logic [3:0] st,
                            input logic [3:0] fl, input logic pcl,
                            input logic [29:0] npc, input logic [29:0] epc,
                            input logic [2:0] code, input logic ie);
        exp_t e;
        e.tag = tag;
        e.v   = {st, fl, pcl, npc, epc, code, ie};
        q.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [72:0] o;
        #1;
        e = q.pop_front();
        o = {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall,
             bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush,
             bus.pc_load, bus.new_pc, bus.epc, bus.exp_code_q, bus.int_en};
        total++;
        assert (o === e.v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", e.tag, o, e.v);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] st,
                        input logic [3:0] fl, input logic pcl,
                        input logic [29:0] npc, input logic [29:0] epc,
                        input logic [2:0] code, input logic ie);
        push_exp(tag, st, fl, pcl, npc, epc, code, ie);
        check();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset_ = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_ = 1'b1;

        step("T1_idle", 4'h0, 4'h0, 0, 30'h0, 30'h0, 3'd0, 0);

        bus.mem_en = 1; bus.mem_pc = 30'h40; bus.mem_exp_code = 3'd2;
        step("T2_trap", 4'h0, 4'hF, 0, 30'h0, 30'h0, 3'd0, 0);
        idle();
        step("T2_redir", 4'h0, 4'h8, 1, 30'h100, 30'h40, 3'd2, 0);
        step("T2_run", 4'h0, 4'h0, 0, 30'h0, 30'h40, 3'd2, 0);

        bus.int_en_we = 1; bus.int_en_wd = 1;
        step("ien_wr", 4'h0, 4'h0, 0, 30'h0, 30'h40, 3'd2, 0);
        idle();
        step("ien_set", 4'h0, 4'h0, 0, 30'h0, 30'h40, 3'd2, 1);

        bus.mem_en = 1; bus.mem_pc = 30'h50; bus.mem_exp_code = 3'd3;
        step("T3_trap", 4'h0, 4'hF, 0, 30'h0, 30'h40, 3'd2, 1);
        idle();
        bus.if_busy = 1;
        for (int i = 0; i < 3; i++)
            step("T3_busy", 4'hF, 4'h8, 1, 30'h100, 30'h50, 3'd3, 0);
        bus.if_busy = 0;
        step("T3_exit", 4'h0, 4'h8, 1, 30'h100, 30'h50, 3'd3, 0);
        step("T3_run", 4'h0, 4'h0, 0, 30'h0, 30'h50, 3'd3, 0);

        bus.mem_en = 1; bus.mem_eret = 1;
        step("T4_eret", 4'h0, 4'hF, 0, 30'h0, 30'h50, 3'd3, 0);
        idle();
        step("T4_redir", 4'h0, 4'h8, 1, 30'h50, 30'h50, 3'd3, 1);
        step("T4_run", 4'h0, 4'h0, 0, 30'h0, 30'h50, 3'd3, 1);

        bus.br_taken = 1; bus.br_addr = 30'h20; bus.ld_hazard = 1;
        step("T5_br_ld", 4'h0, 4'h8, 1, 30'h20, 30'h50, 3'd3, 1);
        bus.br_taken = 0;
        step("T5_ld", 4'h8, 4'h4, 0, 30'h0, 30'h50, 3'd3, 1);
        bus.br_taken = 1; bus.mem_busy = 1;
        step("T5_br_busy", 4'hF, 4'h0, 0, 30'h0, 30'h50, 3'd3, 1);
        idle();
        bus.if_busy = 1; bus.mem_en = 1;
        bus.mem_pc = 30'h70; bus.mem_exp_code = 3'd2;
        step("trap_busy", 4'hF, 4'h0, 0, 30'h0, 30'h50, 3'd3, 1);
        idle();
        step("trap_busy_ign", 4'h0, 4'h0, 0, 30'h0, 30'h50, 3'd3, 1);

        bus.mem_en = 1; bus.mem_pc = 30'h60; bus.int_req = 1;
        bus.int_en_we = 1; bus.int_en_wd = 1;
        step("irq_trap", 4'h0, 4'hF, 0, 30'h0, 30'h50, 3'd3, 1);
        idle();
        step("irq_redir", 4'h0, 4'h8, 1, 30'h100, 30'h60, 3'd1, 0);
        step("irq_run", 4'h0, 4'h0, 0, 30'h0, 30'h60, 3'd1, 0);

        bus.int_en_we = 1; bus.int_en_wd = 1;
        step("ien_wr2", 4'h0, 4'h0, 0, 30'h0, 30'h60, 3'd1, 0);
        idle();

        bus.mem_en = 1; bus.mem_halt = 1; bus.mem_pc = 30'h80;
        step("T6_halt", 4'h0, 4'hE, 0, 30'h0, 30'h60, 3'd1, 1);
        for (int i = 0; i < 5; i++)
            step("T6_hold", 4'hF, 4'h0, 0, 30'h0, 30'h60, 3'd1, 1);
        bus.int_req = 1;
        step("T6_irq", 4'hF, 4'h0, 0, 30'h0, 30'h60, 3'd1, 1);
        idle();
        step("T6_redir", 4'h0, 4'h8, 1, 30'h100, 30'h81, 3'd1, 0);
        step("T6_run", 4'h0, 4'h0, 0, 30'h0, 30'h81, 3'd1, 0);

        bus.mem_en = 1; bus.mem_halt = 1; bus.mem_pc = 30'h90;
        step("H2_halt", 4'h0, 4'hE, 0, 30'h0, 30'h81, 3'd1, 0);
        bus.int_req = 1;
        step("H2_irq_masked", 4'hF, 4'h0, 0, 30'h0, 30'h81, 3'd1, 0);
        step("H2_hold", 4'hF, 4'h0, 0, 30'h0, 30'h81, 3'd1, 0);
        idle();
        reset_ = 1'b0;
        step("rst_in_halt", 4'hF, 4'h0, 0, 30'h0, 30'h81, 3'd1, 0);
        reset_ = 1'b1;
        step("rst_after", 4'h0, 4'h0, 0, 30'h0, 30'h0, 3'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
